// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    // Column drive value after reset: leftmost column (col[0]) active-low.
    localparam logic [3:0] COL_RESET = 4'b1110;

    // Key map indexed by {row_idx, col_idx}; row 0 is the top row, col 0 the left column.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    // True when exactly one of the four active-low lines is low.
    function automatic logic one_low(input logic [3:0] v);
        logic res;
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

    // Index of the single low bit; only meaningful when one_low() holds.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_tick.sv
// scan_tick_gen: free-running divider producing a registered one-cycle strobe
// every SCAN_DIV clock cycles; the first strobe takes effect SCAN_DIV cycles
// after reset is released.
module scan_tick_gen #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SCAN_DIV - 2);

    logic [CNT_W-1:0] div_cnt_r;
    logic             tick_r;

    // Divider counter; the strobe is registered one count early so that it is
    // high during the cycle whose closing edge is the SCAN_DIV-th edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= {CNT_W{1'b0}};
            tick_r    <= 1'b0;
        end else begin
            tick_r <= (div_cnt_r == CNT_PRE);
            if (div_cnt_r == CNT_LAST) begin
                div_cnt_r <= {CNT_W{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + CNT_W'(1);
            end
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning 4x4 keypad reader with row synchronizer,
// tick-based debounce, single-pulse key reporting and an optional two-digit
// entry register built only when KEYPAD_ENTRY_REG_EN is defined.
import keypad_pkg::*;

module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [7:0] entry
);

    localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             tick_s;
    logic [3:0]       row_meta_r;
    logic [3:0]       rs_r;
    kp_state_e        state_r,    state_s;
    logic [3:0]       col_r,      col_s;
    logic [CNT_W-1:0] count_r,    count_s;
    logic [3:0]       cap_r,      cap_s;
    logic [3:0]       key_code_r, key_code_s;
    logic             key_valid_r, key_valid_s;
    logic             key_held_r,  key_held_s;
    logic             accept_s;
    logic [3:0]       col_rot_s;
    logic [3:0]       key_lookup_s;
    logic [CNT_W-1:0] count_inc_s;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Two-flop synchronizer for the asynchronous row inputs (idle high).
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_r <= 4'hF;
            rs_r       <= 4'hF;
        end else begin
            row_meta_r <= row;
            rs_r       <= row_meta_r;
        end
    end

    assign col_rot_s    = {col_r[2:0], col_r[3]};
    assign key_lookup_s = KEY_MAP[{low_index(rs_r), low_index(col_r)}];
    assign count_inc_s  = count_r + CNT_ONE;

    // Next-state and next-output logic; all decisions are taken on scan ticks.
    always_comb begin
        state_s     = state_r;
        col_s       = col_r;
        count_s     = count_r;
        cap_s       = cap_r;
        key_code_s  = key_code_r;
        key_valid_s = 1'b0;
        key_held_s  = key_held_r;
        accept_s    = 1'b0;
        if (tick_s) begin
            case (state_r)
                SCAN: begin
                    if (one_low(rs_r)) begin
                        cap_s   = rs_r;
                        count_s = CNT_ONE;
                        if (CNT_ONE == CNT_DONE) begin
                            state_s     = PRESSED;
                            key_code_s  = key_lookup_s;
                            key_valid_s = 1'b1;
                            key_held_s  = 1'b1;
                            accept_s    = 1'b1;
                        end else begin
                            state_s = DEBOUNCE;
                        end
                    end else begin
                        col_s = col_rot_s;
                    end
                end
                DEBOUNCE: begin
                    if (rs_r == cap_r) begin
                        count_s = count_inc_s;
                        if (count_inc_s == CNT_DONE) begin
                            state_s     = PRESSED;
                            key_code_s  = key_lookup_s;
                            key_valid_s = 1'b1;
                            key_held_s  = 1'b1;
                            accept_s    = 1'b1;
                        end else begin
                            state_s = DEBOUNCE;
                        end
                    end else begin
                        state_s = SCAN;
                        col_s   = col_rot_s;
                    end
                end
                PRESSED: begin
                    if (rs_r == 4'hF) begin
                        count_s = CNT_ONE;
                        if (CNT_ONE == CNT_DONE) begin
                            state_s    = SCAN;
                            key_held_s = 1'b0;
                            col_s      = col_rot_s;
                        end else begin
                            state_s = RELEASE;
                        end
                    end else begin
                        state_s = PRESSED;
                    end
                end
                RELEASE: begin
                    if (rs_r == 4'hF) begin
                        count_s = count_inc_s;
                        if (count_inc_s == CNT_DONE) begin
                            state_s    = SCAN;
                            key_held_s = 1'b0;
                            col_s      = col_rot_s;
                        end else begin
                            state_s = RELEASE;
                        end
                    end else begin
                        state_s = PRESSED;
                    end
                end
                default: begin
                    state_s    = SCAN;
                    col_s      = COL_RESET;
                    count_s    = {CNT_W{1'b0}};
                    key_held_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SCAN;
            col_r       <= COL_RESET;
            count_r     <= {CNT_W{1'b0}};
            cap_r       <= 4'hF;
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            col_r       <= col_s;
            count_r     <= count_s;
            cap_r       <= cap_s;
            key_code_r  <= key_code_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
        end
    end

`ifdef KEYPAD_ENTRY_REG_EN
    logic [7:0] entry_r;

    // Two-digit entry register: each accepted key shifts in as the low digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_r <= 8'h00;
        end else if (accept_s) begin
            entry_r <= {entry_r[3:0], key_lookup_s};
        end else begin
            entry_r <= entry_r;
        end
    end

    assign entry = entry_r;
`else
    assign entry = 8'h00;
`endif

    assign col       = col_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4 and
// DEBOUNCE_SCANS=3. A small keypad model pulls a row low whenever the pressed
// key's column is driven; an override forces arbitrary row patterns.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [7:0] entry;

    logic       key_on;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic       ovr_en;
    logic [3:0] ovr_row;

    int checks;
    int failures;
    int pulse_cnt;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .entry     (entry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: the pressed key shorts its row to its column line.
    always_comb begin
        row = 4'hF;
        if (ovr_en) begin
            row = ovr_row;
        end else if (key_on && (col == key_col)) begin
            row = key_row;
        end else begin
            row = 4'hF;
        end
    end

    // Count every cycle in which key_valid is high.
    always @(posedge clk) begin
        if (key_valid === 1'b1) pulse_cnt = pulse_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic press(input int r, input int c);
        key_row    = 4'hF;
        key_col    = 4'hF;
        key_row[r] = 1'b0;
        key_col[c] = 1'b0;
        key_on     = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Wait for col to leave target, then for it to arrive at target.
    task automatic wait_col_fresh(input logic [3:0] target, output bit seen);
        bit left;
        left = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (col !== target) begin
                left = 1'b1;
                break;
            end
        end
        if (left) begin
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                if (col === target) begin
                    seen = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic wait_held_clear(output int lat);
        lat = 0;
        while ((key_held !== 1'b0) && (lat < 60)) begin
            @(negedge clk);
            lat = lat + 1;
        end
    endtask

    initial begin
        bit seen;
        int lat;
        checks    = 0;
        failures  = 0;
        pulse_cnt = 0;
        key_on    = 1'b0;
        key_row   = 4'hF;
        key_col   = 4'hF;
        ovr_en    = 1'b0;
        ovr_row   = 4'hF;
        rst       = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_col", 32'(col), 32'(4'b1110));
        check_eq("rst_valid", 32'(key_valid), 32'd0);
        check_eq("rst_held", 32'(key_held), 32'd0);
        check_eq("rst_code", 32'(key_code), 32'd0);
        check_eq("rst_entry", 32'(entry), 32'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rot_n3", 32'(col), 32'(4'b1110));
        @(negedge clk);
        check_eq("rot_n4", 32'(col), 32'(4'b1101));
        repeat (4) @(negedge clk);
        check_eq("rot_n8", 32'(col), 32'(4'b1011));
        repeat (4) @(negedge clk);
        check_eq("rot_n12", 32'(col), 32'(4'b0111));
        repeat (4) @(negedge clk);
        check_eq("rot_n16", 32'(col), 32'(4'b1110));

        // Clean press of 5 (row 1, column 1)
        press(1, 1);
        wait_valid(100, seen);
        check_eq("p5_seen", 32'(seen), 32'd1);
        check_eq("p5_code", 32'(key_code), 32'h5);
        check_eq("p5_held", 32'(key_held), 32'd1);
        check_eq("p5_col", 32'(col), 32'(4'b1101));
        @(negedge clk);
        check_eq("p5_valid_1cyc", 32'(key_valid), 32'd0);
        repeat (20) @(negedge clk);
        check_eq("p5_no_repeat", 32'(pulse_cnt), 32'd1);
        check_eq("p5_col_fixed", 32'(col), 32'(4'b1101));
        key_on = 1'b0;
        wait_held_clear(lat);
        check_eq("p5_release_lat", 32'((lat >= 11) && (lat <= 14)), 32'd1);
        check_eq("p5_rot_resume", 32'(col), 32'(4'b1011));

        // Bounce on D (row 3, column 3): one-tick glitch, then a real press
        wait_col_fresh(4'b0111, seen);
        check_eq("bnc_col_seen", 32'(seen), 32'd1);
        press(3, 3);
        repeat (4) @(negedge clk);
        key_on = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("bnc_no_pulse", 32'(pulse_cnt), 32'd1);
        check_eq("bnc_rot", 32'(col), 32'(4'b1110));
        press(3, 3);
        wait_valid(100, seen);
        check_eq("pD_seen", 32'(seen), 32'd1);
        check_eq("pD_code", 32'(key_code), 32'hD);
`ifdef KEYPAD_ENTRY_REG_EN
        check_eq("pD_entry", 32'(entry), 32'h5D);
`else
        check_eq("pD_entry", 32'(entry), 32'h00);
`endif
        repeat (2) @(negedge clk);
        check_eq("pD_count", 32'(pulse_cnt), 32'd2);
        key_on = 1'b0;
        wait_held_clear(lat);
        check_eq("pD_release", 32'(key_held), 32'd0);

        // Entry: press 7 then A
        press(2, 0);
        wait_valid(100, seen);
        check_eq("p7_seen", 32'(seen), 32'd1);
        check_eq("p7_code", 32'(key_code), 32'h7);
        key_on = 1'b0;
        wait_held_clear(lat);
        press(0, 3);
        wait_valid(100, seen);
        check_eq("pA_seen", 32'(seen), 32'd1);
        check_eq("pA_code", 32'(key_code), 32'hA);
`ifdef KEYPAD_ENTRY_REG_EN
        check_eq("pA_entry", 32'(entry), 32'h7A);
`else
        check_eq("pA_entry", 32'(entry), 32'h00);
`endif
        key_on = 1'b0;
        wait_held_clear(lat);
        check_eq("pA_release", 32'(key_held), 32'd0);
        check_eq("pA_count", 32'(pulse_cnt), 32'd4);

        // Two rows low at once: ignored, scanning continues
        ovr_row = 4'b0011;
        ovr_en  = 1'b1;
        wait_col_fresh(4'b1110, seen);
        check_eq("multi_col_seen", 32'(seen), 32'd1);
        repeat (4) @(negedge clk);
        check_eq("multi_rot1", 32'(col), 32'(4'b1101));
        repeat (4) @(negedge clk);
        check_eq("multi_rot2", 32'(col), 32'(4'b1011));
        repeat (16) @(negedge clk);
        check_eq("multi_no_pulse", 32'(pulse_cnt), 32'd4);
        check_eq("multi_held", 32'(key_held), 32'd0);
        ovr_en = 1'b0;

        // Reset during DEBOUNCE on key 0 (row 3, column 0)
        wait_col_fresh(4'b1110, seen);
        check_eq("rmp_col_seen", 32'(seen), 32'd1);
        press(3, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rmp_col", 32'(col), 32'(4'b1110));
        check_eq("rmp_valid", 32'(key_valid), 32'd0);
        check_eq("rmp_held", 32'(key_held), 32'd0);
        check_eq("rmp_code", 32'(key_code), 32'd0);
        check_eq("rmp_entry", 32'(entry), 32'h00);
        check_eq("rmp_no_pulse", 32'(pulse_cnt), 32'd4);
        rst = 1'b0;
        wait_valid(100, seen);
        check_eq("p0_seen", 32'(seen), 32'd1);
        check_eq("p0_code", 32'(key_code), 32'h0);
        check_eq("p0_held", 32'(key_held), 32'd1);
        repeat (10) @(negedge clk);
        check_eq("p0_count", 32'(pulse_cnt), 32'd5);
        key_on = 1'b0;
        wait_held_clear(lat);
        check_eq("p0_release", 32'(key_held), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart to the multiplexed seven-segment driver: it drives the four column lines of a 4x4 matrix keypad (Pmod KYPD on the Artix-7 board) one at a time, reads the row lines, debounces, and reports one hex key code per press. It feeds operand entry for the counter/shifter/ALU datapath, replacing the inp_top_a/inp_top_b slide switches, with an optional two-digit entry register.

## Interface
- SCAN_DIV, 100000: clk cycles per scan tick (1 ms at 100 MHz); must be >= 2.
- DEBOUNCE_SCANS, 4: consecutive identical ticks required to accept a press or a release; must be >= 1.
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- row  input  4  keypad rows, active-low, externally pulled up; asynchronous.
- col  output  4  keypad columns, active-low, exactly one bit low at all times.
- key_code  output  4  hex value of the last accepted key; holds until the next accept.
- key_valid  output  1  one-cycle pulse per accepted press.
- key_held  output  1  high from the accept until the release is debounced.
- entry  output  8  two-digit entry register; a new key shifts in as {entry[3:0], key_code}.

## Operation
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_held=0, entry=0, state SCAN, tick divider=0, debounce count=0.
- row passes through a 2-flop synchronizer; all decisions use the synchronized value rs, sampled only on scan ticks.
- Key map (row r top-down, col c left-right): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: 0 F E D.
- SCAN:
  - On a tick, if rs has exactly one low bit, capture rs, set count=1, and go to DEBOUNCE. The column stays fixed.
  - Otherwise, rotate col left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Zero or multiple low rows, including ghosting and two keys in one column, leave the scanner in SCAN.
- DEBOUNCE:
  - On a tick with rs equal to the captured value, count++.
  - When count reaches DEBOUNCE_SCANS, go to PRESSED. On that same edge, load key_code, pulse key_valid, set key_held, and shift entry.
  - On a tick with any other rs value, return to SCAN and rotate col. No output changes.
  - When DEBOUNCE_SCANS=1, the capture tick itself performs the accept and the state passes directly SCAN -> PRESSED.
- PRESSED:
  - The column stays fixed.
  - On a tick with rs=4'hF, set count=1 and go to RELEASE.
  - Additional keys are ignored; no repeat.
- RELEASE:
  - On a tick with rs=4'hF, count++. At DEBOUNCE_SCANS, go to SCAN, clear key_held, and rotate col.
  - On a tick with any low row, return to PRESSED. key_held stays high and no new pulse is issued.
- Reset asserted in any state forces all reset values on the next edge. A press in progress is discarded.

## Timing
- The tick is an internal one-cycle strobe every SCAN_DIV clk cycles. The first tick occurs SCAN_DIV cycles after reset deasserts.
- col changes only on the clk edge of a tick, so rows settle for a full tick period before they are sampled.
- Latency from a stable press to key_valid:
  - Best case: 2 clk cycles for synchronization, plus alignment to the column, plus (DEBOUNCE_SCANS-1) ticks after the capture tick.
  - Worst case: 4*SCAN_DIV + DEBOUNCE_SCANS*SCAN_DIV + 2 clk cycles.
- key_valid is registered and high for exactly one clk cycle. key_code and entry update on the same edge.
- Between accepts, key_code and entry are stable.

## Configuration
- KEYPAD_ENTRY_REG_EN defined: entry is implemented as described.
- KEYPAD_ENTRY_REG_EN undefined: no entry flops are built, and entry is tied to 8'h00. All other behaviour is identical.

## Structure
- Shared package keypad_pkg contains:
  - the state enum (SCAN, DEBOUNCE, PRESSED, RELEASE);
  - the 16-entry key-map constant indexed by {row_idx, col_idx};
  - the column reset value 4'b1110.
- One sub-module, scan_tick_gen (parameter SCAN_DIV; ports clk, rst, tick), holds the free-running divider.
- The FSM, synchronizer, debounce counter, and entry register live in keypad_scanner.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3; rows idle 4'hF.
- Reset: hold rst for 3 cycles -> col=1110, key_valid=0, key_held=0, key_code=0, entry=00, and col rotates every 4 cycles after release.
- Clean press: drive row[1] low whenever col=1101, held -> exactly one key_valid pulse with key_code=5 and key_held=1; release -> key_held clears 3 ticks later and rotation resumes.
- Bounce: assert row[3] on col=0111 for 1 tick, release for 1 tick, then hold -> no pulse from the glitch, then one pulse with key_code=D.
- Entry: press 7 then release, then press A -> entry=8'h7A; with KEYPAD_ENTRY_REG_EN undefined -> entry stays 8'h00.
- Multiple rows: drive row=4'b0011 on any column -> no pulse and col keeps rotating.
- Reset mid-press: assert rst while in DEBOUNCE -> key_valid never pulses, all outputs return to reset values, and a subsequent press of 0 reports key_code=0 with one pulse.
